// File: rtl/calib_pulse_pkg.sv
// Shared types and defaults for the calibration pulse generator.
package calib_pulse_pkg;

   localparam int DW_DEF    = 8;
   localparam int CNT_W_DEF = 16;

   localparam int                DROP_W   = 8;
   localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DLY  = 2'd1,
      PLS  = 2'd2,
      HOLD = 2'd3
   } state_e;

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_DLY  = DLY;
   localparam logic [1:0] ST_PLS  = PLS;
   localparam logic [1:0] ST_HOLD = HOLD;

endpackage

// File: rtl/calib_trg_sync.sv
// Two-flop synchroniser for an asynchronous LV trigger followed by a
// rising-edge detector; edge_req is high for one cycle per rising edge.
module calib_trg_sync (
   input  logic CLK,
   input  logic RST_N,
   input  logic trg,
   output logic edge_req
);

   logic s1, s2, s3;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         {s3, s2, s1} <= 3'b000;
      end else begin
         {s3, s2, s1} <= {s2, s1, trg};
      end
   end

   assign edge_req = s2 & ~s3;

endmodule

// File: rtl/calib_pulse_gen.sv
// Calibration pulse sequencer: delay, pulse, hold-off per accepted trigger,
// with accepted/dropped counters for slow-control readback.
module calib_pulse_gen
   import calib_pulse_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              ENABLE,
   input  logic              TRG_EXT,
   input  logic              TRG_INJ,
   input  logic              SW_EXT,
   input  logic              SW_INJ,
   input  logic [DW-1:0]     DELAY,
   input  logic [DW-1:0]     WIDTH,
   input  logic [DW-1:0]     HOLDOFF,
   input  logic              CNT_CLR,
   output logic              EXT_PULSE,
   output logic              INJ_PULSE,
   output logic              BUSY,
   output logic [CNT_W-1:0]  PLS_CNT,
   output logic [DROP_W-1:0] DROP_CNT,
   output logic [1:0]        DBG_STATE
);

   logic          edge_ext, edge_inj;
   logic          ext_req, inj_req, any_req;
   logic          accept, drop;
   logic [1:0]    state;
   logic [DW-1:0] cnt, width_q, hold_q;
   logic [DW-1:0] width_in_m1, width_q_m1;
   logic          mask_ext, mask_inj;

   calib_trg_sync u_sync_ext (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .trg      (TRG_EXT),
      .edge_req (edge_ext)
   );

   calib_trg_sync u_sync_inj (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .trg      (TRG_INJ),
      .edge_req (edge_inj)
   );

   // Requests are one-cycle strobes with no back-pressure: one arriving in
   // IDLE with ENABLE high is accepted, one arriving while busy is dropped.
   assign ext_req = edge_ext | SW_EXT;
   assign inj_req = edge_inj | SW_INJ;
   assign any_req = ext_req | inj_req;
   assign accept  = ENABLE && (state == ST_IDLE) && any_req;
   assign drop    = ENABLE && (state != ST_IDLE) && any_req;

   // A zero width still produces a single-cycle pulse.
   assign width_in_m1 = (WIDTH == '0)   ? '0 : WIDTH - DW'(1);
   assign width_q_m1  = (width_q == '0) ? '0 : width_q - DW'(1);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         width_q   <= '0;
         hold_q    <= '0;
         mask_ext  <= 1'b0;
         mask_inj  <= 1'b0;
         EXT_PULSE <= 1'b0;
         INJ_PULSE <= 1'b0;
      end else if (!ENABLE) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         EXT_PULSE <= 1'b0;
         INJ_PULSE <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  mask_ext <= ext_req;
                  mask_inj <= inj_req;
                  width_q  <= WIDTH;
                  hold_q   <= HOLDOFF;
                  if (DELAY == '0) begin
                     state     <= ST_PLS;
                     cnt       <= width_in_m1;
                     EXT_PULSE <= ext_req;
                     INJ_PULSE <= inj_req;
                  end else begin
                     state <= ST_DLY;
                     cnt   <= DELAY - DW'(1);
                  end
               end
            end
            ST_DLY: begin
               if (cnt == '0) begin
                  state     <= ST_PLS;
                  cnt       <= width_q_m1;
                  EXT_PULSE <= mask_ext;
                  INJ_PULSE <= mask_inj;
               end else begin
                  cnt <= cnt - DW'(1);
               end
            end
            ST_PLS: begin
               if (cnt == '0) begin
                  EXT_PULSE <= 1'b0;
                  INJ_PULSE <= 1'b0;
                  if (hold_q == '0) begin
                     state <= ST_IDLE;
                  end else begin
                     state <= ST_HOLD;
                     cnt   <= hold_q - DW'(1);
                  end
               end else begin
                  cnt <= cnt - DW'(1);
               end
            end
            ST_HOLD: begin
               if (cnt == '0) begin
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - DW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Clear wins over a same-cycle increment.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         PLS_CNT  <= '0;
         DROP_CNT <= '0;
      end else if (CNT_CLR) begin
         PLS_CNT  <= '0;
         DROP_CNT <= '0;
      end else begin
         if (accept) begin
            PLS_CNT <= PLS_CNT + CNT_W'(1);
         end
         if (drop && (DROP_CNT != DROP_MAX)) begin
            DROP_CNT <= DROP_CNT + DROP_W'(1);
         end
      end
   end

   assign BUSY      = (state != ST_IDLE);
   assign DBG_STATE = state;

endmodule

// File: tb/tb_calib_pulse_gen.sv
// Bench for calib_pulse_gen: timeline-based reference model, per-cycle
// scoreboard, directed scenarios with literal expectations, random traffic.
module tb_calib_pulse_gen;
   import calib_pulse_pkg::*;

   localparam int DW    = 8;
   localparam int CNT_W = 16;
   localparam int VW    = 3 + CNT_W + DROP_W;

   logic              CLK = 1'b0;
   logic              RST_N, ENABLE, TRG_EXT, TRG_INJ, SW_EXT, SW_INJ, CNT_CLR;
   logic [DW-1:0]     DELAY, WIDTH, HOLDOFF;
   logic              EXT_PULSE, INJ_PULSE, BUSY;
   logic [CNT_W-1:0]  PLS_CNT;
   logic [DROP_W-1:0] DROP_CNT;
   logic [1:0]        DBG_STATE;

   int n_vec  = 0;
   int n_miss = 0;
   logic [VW-1:0] exp_q[$];

   calib_pulse_gen #(.DW(DW), .CNT_W(CNT_W)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .ENABLE    (ENABLE),
      .TRG_EXT   (TRG_EXT),
      .TRG_INJ   (TRG_INJ),
      .SW_EXT    (SW_EXT),
      .SW_INJ    (SW_INJ),
      .DELAY     (DELAY),
      .WIDTH     (WIDTH),
      .HOLDOFF   (HOLDOFF),
      .CNT_CLR   (CNT_CLR),
      .EXT_PULSE (EXT_PULSE),
      .INJ_PULSE (INJ_PULSE),
      .BUSY      (BUSY),
      .PLS_CNT   (PLS_CNT),
      .DROP_CNT  (DROP_CNT),
      .DBG_STATE (DBG_STATE)
   );

   // ---------------- clock ----------------
   always #5 CLK = ~CLK;

   // ---------------- reference model ----------------
   // A sequence accepted at edge a occupies edges a .. a+d+w+h-1 and drives
   // its pulse after edges a+d .. a+d+w-1.
   int   m_cyc, m_a, m_d, m_w, m_h, m_end, m_pls, m_drop;
   logic m_active, m_me, m_mi;
   logic [2:0] th_ext, th_inj;
   logic rq_e, rq_i, busy_before, acc, x_ext, x_inj, x_busy;

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_cyc = 0; m_active = 1'b0; m_me = 1'b0; m_mi = 1'b0;
         m_a = 0; m_d = 0; m_w = 1; m_h = 0; m_end = 0;
         m_pls = 0; m_drop = 0;
         th_ext = 3'b000; th_inj = 3'b000;
         exp_q.delete();
         exp_q.push_back('0);
      end else begin
         m_cyc++;
         // TRG history: bit k = value sampled k+1 edges ago
         rq_e = (th_ext[1] & ~th_ext[2]) | SW_EXT;
         rq_i = (th_inj[1] & ~th_inj[2]) | SW_INJ;
         th_ext = {th_ext[1:0], TRG_EXT};
         th_inj = {th_inj[1:0], TRG_INJ};
         busy_before = m_active && (m_cyc <= m_end);
         acc = 1'b0;
         if (!ENABLE) begin
            m_active = 1'b0;
         end else if (rq_e || rq_i) begin
            if (busy_before) begin
               if (m_drop < 255) m_drop++;
            end else begin
               acc = 1'b1;
               m_active = 1'b1;
               m_a = m_cyc;
               m_d = int'(DELAY);
               m_w = (WIDTH == 0) ? 1 : int'(WIDTH);
               m_h = int'(HOLDOFF);
               m_me = rq_e;
               m_mi = rq_i;
               m_end = m_a + m_d + m_w + m_h;
            end
         end
         if (acc) m_pls = (m_pls + 1) % (1 << CNT_W);
         if (CNT_CLR) begin
            m_pls = 0;
            m_drop = 0;
         end
         x_busy = m_active && (m_cyc < m_end);
         x_ext  = m_active && m_me && (m_cyc >= m_a + m_d) && (m_cyc < m_a + m_d + m_w);
         x_inj  = m_active && m_mi && (m_cyc >= m_a + m_d) && (m_cyc < m_a + m_d + m_w);
         exp_q.push_back({x_ext, x_inj, x_busy, CNT_W'(m_pls), DROP_W'(m_drop)});
      end
   end

   // ---------------- scoreboard compare ----------------
   logic [VW-1:0] exp_v, act_v;
   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         act_v = {EXT_PULSE, INJ_PULSE, BUSY, PLS_CNT, DROP_CNT};
         n_vec++;
         if (act_v !== exp_v) begin
            n_miss++;
            $display("FAIL cycle_check t=%0t ext/inj/busy/pls/drop got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                     $time, act_v[VW-1], act_v[VW-2], act_v[VW-3], act_v[CNT_W+DROP_W-1:DROP_W],
                     act_v[DROP_W-1:0], exp_v[VW-1], exp_v[VW-2], exp_v[VW-3],
                     exp_v[CNT_W+DROP_W-1:DROP_W], exp_v[DROP_W-1:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int k);
      repeat (k) @(posedge CLK);
      #1;
   endtask

   task automatic strobe(input logic e, input logic i, input logic c);
      @(negedge CLK);
      SW_EXT = e; SW_INJ = i; CNT_CLR = c;
      @(posedge CLK);
      #1;
      SW_EXT = 1'b0; SW_INJ = 1'b0; CNT_CLR = 1'b0;
   endtask

   task automatic set_cfg(input int d, input int w, input int h);
      DELAY = DW'(d); WIDTH = DW'(w); HOLDOFF = DW'(h);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      RST_N = 1'b0; ENABLE = 1'b1; TRG_EXT = 1'b0; TRG_INJ = 1'b0;
      SW_EXT = 1'b0; SW_INJ = 1'b0; CNT_CLR = 1'b0;
      set_cfg(0, 0, 0);
      tick(1);
      chk("rst_ext", EXT_PULSE, 0);
      chk("rst_inj", INJ_PULSE, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_pls_cnt", PLS_CNT, 0);
      chk("rst_drop_cnt", DROP_CNT, 0);
      tick(2);
      @(negedge CLK); RST_N = 1'b1;
      tick(2);

      // SW ext, delay 4 width 3 holdoff 2
      set_cfg(4, 3, 2);
      strobe(1'b1, 1'b0, 1'b0);
      tick(3); chk("s1_ext_before", EXT_PULSE, 0);
      tick(1); chk("s1_ext_rise", EXT_PULSE, 1); chk("s1_busy", BUSY, 1);
      tick(2); chk("s1_ext_last", EXT_PULSE, 1); chk("s1_inj", INJ_PULSE, 0);
      tick(1); chk("s1_ext_fall", EXT_PULSE, 0);
      tick(1); chk("s1_busy_hold", BUSY, 1);
      tick(1); chk("s1_busy_end", BUSY, 0); chk("s1_pls_cnt", PLS_CNT, 1);

      // TRG_INJ held high, delay 0 width 0
      set_cfg(0, 0, 1);
      @(negedge CLK); TRG_INJ = 1'b1;
      tick(1);
      tick(1); chk("s2_inj_e1", INJ_PULSE, 0);
      tick(1); chk("s2_inj_e2", INJ_PULSE, 1);
      tick(1); chk("s2_inj_e3", INJ_PULSE, 0);
      tick(47); TRG_INJ = 1'b0;
      chk("s2_pls_cnt", PLS_CNT, 2);
      tick(3);

      // both channels, then three drops
      set_cfg(2, 5, 3);
      strobe(1'b1, 1'b1, 1'b0);
      tick(1); chk("s3_ext_e1", EXT_PULSE, 0);
      tick(1); chk("s3_ext_e2", EXT_PULSE, 1); chk("s3_inj_e2", INJ_PULSE, 1);
      repeat (3) strobe(1'b1, 1'b0, 1'b0);
      chk("s3_drop_cnt", DROP_CNT, 3);
      tick(1); chk("s3_inj_e6", INJ_PULSE, 1);
      tick(1); chk("s3_ext_e7", EXT_PULSE, 0); chk("s3_inj_e7", INJ_PULSE, 0);
      chk("s3_pls_cnt", PLS_CNT, 3);
      tick(5);

      // config change mid-sequence has no effect on the running one
      set_cfg(4, 3, 0);
      strobe(1'b1, 1'b0, 1'b0);
      tick(1); set_cfg(1, 10, 0);
      tick(2); chk("s4_ext_e3", EXT_PULSE, 0);
      tick(1); chk("s4_ext_e4", EXT_PULSE, 1);
      tick(2); chk("s4_ext_e6", EXT_PULSE, 1);
      tick(1); chk("s4_ext_e7", EXT_PULSE, 0); chk("s4_busy_e7", BUSY, 0);
      strobe(1'b0, 1'b1, 1'b0);
      tick(1); chk("s4_inj_rise", INJ_PULSE, 1);
      tick(9); chk("s4_inj_last", INJ_PULSE, 1);
      tick(1); chk("s4_inj_fall", INJ_PULSE, 0);
      chk("s4_pls_cnt", PLS_CNT, 5);
      tick(2);

      // ENABLE dropped during the pulse
      set_cfg(1, 8, 2);
      strobe(1'b1, 1'b0, 1'b0);
      tick(2); chk("s5_ext_on", EXT_PULSE, 1);
      ENABLE = 1'b0;
      tick(1); chk("s5_ext_abort", EXT_PULSE, 0); chk("s5_busy_abort", BUSY, 0);
      ENABLE = 1'b1;
      strobe(1'b0, 1'b1, 1'b0);
      tick(1); chk("s5_inj_rise", INJ_PULSE, 1);
      chk("s5_pls_cnt", PLS_CNT, 7); chk("s5_drop_kept", DROP_CNT, 3);
      tick(12);

      // drop saturation
      set_cfg(255, 255, 255);
      strobe(1'b1, 1'b0, 1'b0);
      repeat (300) strobe(1'b1, 1'b0, 1'b0);
      chk("s5_drop_sat", DROP_CNT, 255);
      ENABLE = 1'b0;
      tick(1); ENABLE = 1'b1;
      chk("s5_idle_after_abort", BUSY, 0);

      // clear coincident with an accept
      set_cfg(0, 10, 0);
      strobe(1'b1, 1'b0, 1'b1);
      chk("s5_clr_pls", PLS_CNT, 0); chk("s5_clr_drop", DROP_CNT, 0);
      chk("s5_clr_busy", BUSY, 1);

      // asynchronous reset in the middle of the pulse
      tick(2); chk("s6_ext_on", EXT_PULSE, 1);
      #2 RST_N = 1'b0;
      #1;
      chk("s6_ext_async", EXT_PULSE, 0); chk("s6_busy_async", BUSY, 0);
      chk("s6_pls_async", PLS_CNT, 0);
      tick(2);
      @(negedge CLK); RST_N = 1'b1;
      set_cfg(3, 2, 1);
      strobe(1'b1, 1'b0, 1'b0);
      tick(2); chk("s6_ext_e2", EXT_PULSE, 0);
      tick(1); chk("s6_ext_e3", EXT_PULSE, 1);
      chk("s6_pls_cnt", PLS_CNT, 1);
      tick(6);
      @(negedge CLK); TRG_EXT = 1'b1;
      tick(1);
      tick(4); chk("s6_trg_e4", EXT_PULSE, 0);
      tick(1); chk("s6_trg_e5", EXT_PULSE, 1);
      TRG_EXT = 1'b0;
      chk("s6_trg_pls_cnt", PLS_CNT, 2);
      tick(8);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         SW_EXT  = ($urandom_range(0, 15) == 0);
         SW_INJ  = ($urandom_range(0, 15) == 0);
         CNT_CLR = ($urandom_range(0, 199) == 0);
         ENABLE  = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 7) == 0) TRG_EXT = ~TRG_EXT;
         if ($urandom_range(0, 7) == 0) TRG_INJ = ~TRG_INJ;
         if ($urandom_range(0, 31) == 0)
            set_cfg($urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 4));
      end
      @(negedge CLK);
      SW_EXT = 1'b0; SW_INJ = 1'b0; CNT_CLR = 1'b0; ENABLE = 1'b1;
      TRG_EXT = 1'b0; TRG_INJ = 1'b0;
      tick(30);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/calib_pulse_gen.md
Name: calib_pulse_gen

Overview:
- Generates the single-ended calibration pulses that feed the INJPULSE/EXTPULSE differential output buffers; those buffers are currently tied low.
- Triggers come from the LV trigger inputs (asynchronous) or from single-cycle software strobes.
- Each accepted trigger runs one sequence: programmable delay, then a pulse of programmable width, then a hold-off window.
- Tracks accepted-sequence and dropped-trigger counts for slow-control readback.

Parameters:
- DW, 8, width of the DELAY, WIDTH and HOLDOFF fields.
- CNT_W, 16, width of PLS_CNT.

Ports:
- CLK  in  1  system clock; all logic is in this single domain.
- RST_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  when low: triggers are ignored and any in-flight sequence is aborted.
- TRG_EXT  in  1  external-pulse trigger from EXTPLS_LV; asynchronous to CLK.
- TRG_INJ  in  1  injection-pulse trigger from INJPLS_LV; asynchronous to CLK.
- SW_EXT  in  1  software strobe for ext pulse; 1-cycle, synchronous to CLK.
- SW_INJ  in  1  software strobe for inj pulse; 1-cycle, synchronous to CLK.
- DELAY  in  DW  cycles from request to pulse start.
- WIDTH  in  DW  pulse length in cycles; 0 is treated as 1.
- HOLDOFF  in  DW  dead cycles after the pulse falls.
- CNT_CLR  in  1  synchronous clear of both counters.
- EXT_PULSE  out  1  registered output to the ext OBUFDS.
- INJ_PULSE  out  1  registered output to the inj OBUFDS.
- BUSY  out  1  high whenever state != IDLE.
- PLS_CNT  out  CNT_W  accepted sequences; wraps at 2^CNT_W.
- DROP_CNT  out  8  triggers rejected while busy; saturates at 255.

Behaviour:
- Reset: all outputs 0, state IDLE, sync flops 0, counters 0.
- Trigger synchronisation (TRG_EXT, TRG_INJ): 2-FF synchroniser, then a rising-edge detector (s2 & ~s3).
  - The resulting request is valid for 1 cycle.
  - It appears in the cycle after the 2nd CLK edge that samples the input high.
  - A level held high produces exactly one request.
- Request combining: ext_req = edge_ext | SW_EXT; inj_req = edge_inj | SW_INJ.
- FSM states: IDLE, DLY, PLS, HOLD.
- IDLE:
  - If ENABLE and (ext_req | inj_req): latch the channel mask {ext_req, inj_req} and latch DELAY/WIDTH/HOLDOFF.
  - Latched configuration means input changes mid-sequence have no effect.
  - Increment PLS_CNT.
  - If DELAY == 0, go to PLS with cnt = max(WIDTH,1) - 1; else go to DLY with cnt = DELAY - 1.
- DLY: decrement cnt. At cnt == 0, go to PLS with cnt = max(WIDTH,1) - 1.
- PLS:
  - EXT_PULSE = mask_ext and INJ_PULSE = mask_inj. Both are registered, so they change on the same edge as the state.
  - At cnt == 0:
    - Both pulses fall.
    - If HOLDOFF == 0, go to IDLE; else go to HOLD with cnt = HOLDOFF - 1.
- HOLD: decrement cnt. At cnt == 0, go to IDLE.
- Latency:
  - SW strobe sampled at edge E: pulse rises at edge E + DELAY.
  - TRG sampled high first at edge E: pulse rises at edge E + 2 + DELAY.
  - The pulse stays high for exactly max(WIDTH,1) cycles.
- Simultaneous ext and inj requests in the same cycle: one sequence; both pulses are identical and coincident. PLS_CNT increments by 1.
- Dropped triggers:
  - Any request while state != IDLE and ENABLE = 1 increments DROP_CNT (saturating).
  - Simultaneous ext+inj counts as 1.
  - Requests while ENABLE = 0 are not counted.
- ENABLE falling mid-sequence: on the next edge, state goes to IDLE and both pulses go to 0. Counters are unchanged.
- CNT_CLR: both counters go to 0 on the next edge. A clear has priority over a same-cycle increment.
- Asynchronous RST_N assertion mid-pulse: pulses drop immediately (asynchronously).

Decomposition:
- Package calib_pulse_pkg holds:
  - the FSM state enum (IDLE, DLY, PLS, HOLD);
  - DW and CNT_W defaults;
  - the DROP_CNT width and saturation value (255).
- One sub-module, calib_trg_sync: 2-FF synchroniser plus rising-edge detector, CLK and RST_N. Instantiated twice, once for TRG_EXT and once for TRG_INJ.
- The FSM, counters and output registers stay in calib_pulse_gen.

Test Plan:
- DELAY=4, WIDTH=3, HOLDOFF=2, SW_EXT at edge 10 -> EXT_PULSE high edges 14–16, INJ_PULSE stays 0, BUSY 10–18, PLS_CNT=1.
- DELAY=0, WIDTH=0, TRG_INJ raised before edge 20 and held 50 cycles -> INJ_PULSE high for exactly 1 cycle from edge 22, one sequence only, PLS_CNT=1.
- SW_EXT and SW_INJ together, DELAY=2, WIDTH=5 -> both pulses rise and fall on identical edges, PLS_CNT +1; then 3 SW_EXT strobes during the sequence -> DROP_CNT=3.
- Change DELAY/WIDTH from 4/3 to 1/10 while in DLY -> current pulse still 3 cycles at original timing; next sequence uses 1/10.
- ENABLE dropped during PLS -> pulse 0 next edge, BUSY 0, next request accepted normally; 300 drops -> DROP_CNT=255; CNT_CLR coincident with an accept -> PLS_CNT=0.
- RST_N asserted mid-pulse -> EXT_PULSE/INJ_PULSE 0 without waiting for a clock, counters 0; after release, first request produces the normal latency.
